// File: rtl/xbar_rr_switch_pkg.sv
// Shared definitions for the round-robin crossbar: default sizes, tag field
// positions inside an output beat, and small index helpers.
package xbar_rr_switch_pkg;

  localparam int unsigned XB_N_PORTS_DEF = 4;
  localparam int unsigned XB_DATA_W_DEF  = 8;

  // Width of a port index (source tag / destination), at least one bit.
  function automatic int unsigned xb_id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Output beat layout is {src_id, data}: the tag sits just above the payload.
  function automatic int unsigned xb_tag_msb(input int unsigned id_w, input int unsigned data_w);
    return id_w + data_w - 1;
  endfunction

  function automatic int unsigned xb_tag_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  // Increment modulo n.
  function automatic int unsigned xb_wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/xbar_rr_switch_arb.sv
// Round-robin arbiter for one crossbar output: rotating search from the
// pointer, grant only while enabled, pointer moves past the winner.
module xbar_rr_arb
  import xbar_rr_switch_pkg::*;
#(
  parameter int unsigned N_REQ = XB_N_PORTS_DEF,
  parameter int unsigned IDX_W = xb_id_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             hit;
  int unsigned      idx;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    hit     = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!hit && req[IDX_W'(idx)]) begin
        hit     = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
    gnt   = '0;
    ptr_d = ptr_q;
    if (en && hit) begin
      gnt[gnt_idx] = 1'b1;
      ptr_d        = IDX_W'(xb_wrap_inc(32'(gnt_idx), N_REQ));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/xbar_rr_switch.sv
// N x N registered crossbar: each output has its own round-robin arbiter and
// a one-beat output register; beats leave tagged as {src_id, data}.
module xbar_rr_switch
  import xbar_rr_switch_pkg::*;
#(
  parameter int unsigned N_PORTS = XB_N_PORTS_DEF,
  parameter int unsigned DATA_W  = XB_DATA_W_DEF,
  parameter int unsigned ID_W    = xb_id_w(N_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_PORTS*DATA_W-1:0]        in_data,
  input  logic [N_PORTS*ID_W-1:0]          in_dest,
  input  logic [N_PORTS-1:0]               in_valid,
  output logic [N_PORTS-1:0]               in_ready,
  output logic [N_PORTS*(ID_W+DATA_W)-1:0] out_data,
  output logic [N_PORTS-1:0]               out_valid,
  input  logic [N_PORTS-1:0]               out_ready,
  output logic                             err_drop
);

  localparam int unsigned OUT_W   = ID_W + DATA_W;
  localparam int unsigned TAG_MSB = xb_tag_msb(ID_W, DATA_W);
  localparam int unsigned TAG_LSB = xb_tag_lsb(DATA_W);

  logic [N_PORTS-1:0][DATA_W-1:0]  in_data_a;
  logic [N_PORTS-1:0][ID_W-1:0]    in_dest_a;
  logic [N_PORTS-1:0][N_PORTS-1:0] req;      // [output][input]
  logic [N_PORTS-1:0][N_PORTS-1:0] gnt;      // [output][input]
  logic [N_PORTS-1:0][ID_W-1:0]    gnt_idx;
  logic [N_PORTS-1:0]              load;
  logic [N_PORTS-1:0]              bad;
  logic [N_PORTS-1:0][OUT_W-1:0]   out_data_q, out_data_d;
  logic [N_PORTS-1:0]              out_valid_q, out_valid_d;
  logic                            err_drop_q, err_drop_d;

  assign in_data_a = in_data;
  assign in_dest_a = in_dest;
  assign load      = ~out_valid_q | out_ready;

  // Transpose input requests into per-output request vectors; flag out-of-range destinations.
  always_comb begin
    req = '0;
    bad = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      bad[i] = in_valid[i] && (32'(in_dest_a[i]) >= N_PORTS);
      for (int unsigned d = 0; d < N_PORTS; d++) begin
        req[d][i] = in_valid[i] && (in_dest_a[i] == ID_W'(d));
      end
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_arb
    xbar_rr_arb #(
      .N_REQ (N_PORTS),
      .IDX_W (ID_W)
    ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req[g]),
      .en      (load[g]),
      .gnt     (gnt[g]),
      .gnt_idx (gnt_idx[g])
    );
  end

  // Combinational ready: granted by some output, or swallowed as a bad destination.
  always_comb begin
    in_ready = '0;
    if (!rst) begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        in_ready[i] = bad[i];
        for (int unsigned d = 0; d < N_PORTS; d++) begin
          in_ready[i] = in_ready[i] | gnt[d][i];
        end
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_drop_d  = |bad;
    for (int unsigned d = 0; d < N_PORTS; d++) begin
      if (|gnt[d]) begin
        out_valid_d[d]                   = 1'b1;
        out_data_d[d][TAG_MSB:TAG_LSB]   = gnt_idx[d];
        out_data_d[d][DATA_W-1:0]        = in_data_a[gnt_idx[d]];
      end else if (out_ready[d]) begin
        out_valid_d[d] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      err_drop_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_drop_q  <= err_drop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_xbar_rr_switch.sv
// Bench for xbar_rr_switch: directed scenarios on a 4-port build, bad-destination
// and scoreboard soak on a 3-port build, model-checked random soak on 4 ports.
module tb_xbar_rr_switch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-port instance
  logic [31:0] in_data4;
  logic [7:0]  in_dest4;
  logic [3:0]  in_valid4, in_ready4, out_valid4, out_ready4;
  logic [39:0] out_data4;
  logic        err4;

  // 3-port instance
  logic [23:0] in_data3;
  logic [5:0]  in_dest3;
  logic [2:0]  in_valid3, in_ready3, out_valid3, out_ready3;
  logic [29:0] out_data3;
  logic        err3;

  int checks   = 0;
  int failures = 0;

  xbar_rr_switch #(.N_PORTS(4), .DATA_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .in_dest(in_dest4), .in_valid(in_valid4),
    .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready4), .err_drop(err4)
  );

  xbar_rr_switch #(.N_PORTS(3), .DATA_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_dest(in_dest3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .err_drop(err3)
  );

  task automatic idle_inputs();
    in_data4 = '0; in_dest4 = '0; in_valid4 = '0; out_ready4 = '1;
    in_data3 = '0; in_dest3 = '0; in_valid3 = '0; out_ready3 = '1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    in_valid4 = 4'b0010; in_dest4 = 8'h00; in_data4 = 32'h0000_4200;
    in_valid3 = 3'b010;  in_dest3 = 6'b00_11_00;
    @(negedge clk);
    checks++; if (in_ready4 !== 4'b0010) begin failures++; $display("FAIL pre_reset_ready got=%b exp=%b", in_ready4, 4'b0010); end
    step();
    in_valid4 = '0; in_valid3 = '0;
    @(negedge clk);
    checks++; if (out_valid4 !== 4'b0001 || out_data4[9:0] !== 10'h142) begin failures++; $display("FAIL pre_reset_out got=%b/%h exp=0001/142", out_valid4, out_data4[9:0]); end
    checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL pre_reset_err got=%b exp=1", err3); end
    #2;
    rst = 1'b1;
    in_valid4 = 4'hF; in_dest4 = 8'h00; in_valid3 = 3'b010;
    #1;
    checks++; if (in_ready4 !== 4'b0000 || in_ready3 !== 3'b000) begin failures++; $display("FAIL reset_in_ready got=%b/%b exp=0000/000", in_ready4, in_ready3); end
    checks++; if (out_valid4 !== 4'b0000 || out_valid3 !== 3'b000) begin failures++; $display("FAIL reset_out_valid got=%b/%b exp=0/0", out_valid4, out_valid3); end
    checks++; if (out_data4 !== 40'h0 || err3 !== 1'b0 || err4 !== 1'b0) begin failures++; $display("FAIL reset_data_err got=%h/%b/%b exp=0/0/0", out_data4, err3, err4); end
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid3 = '0;
    @(negedge clk);
    checks++; if (in_ready4 !== 4'b0001) begin failures++; $display("FAIL reset_ptr_zero got=%b exp=%b", in_ready4, 4'b0001); end
  endtask

  task automatic test_single_route();
    do_reset();
    in_valid4 = 4'b0001; in_dest4 = 8'h02; in_data4 = 32'h0000_00A5;
    @(negedge clk);
    checks++; if (in_ready4 !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", in_ready4); end
    step();
    in_valid4 = '0;
    @(negedge clk);
    checks++; if (out_valid4 !== 4'b0100) begin failures++; $display("FAIL single_valid got=%b exp=0100", out_valid4); end
    checks++; if (out_data4[29:20] !== 10'h0A5) begin failures++; $display("FAIL single_data got=%h exp=0a5", out_data4[29:20]); end
    step();
  endtask

  task automatic test_contention();
    logic [9:0] exp_beat;
    do_reset();
    in_valid4 = 4'hF; in_dest4 = 8'h55; in_data4 = 32'h2322_2120;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 5) begin
        checks++; if (in_ready4 !== 4'(1 << (c % 4))) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, in_ready4, 4'(1 << (c % 4))); end
      end
      if (c >= 1) begin
        exp_beat = {2'((c - 1) % 4), 8'(8'h20 + (c - 1) % 4)};
        checks++; if (out_valid4 !== 4'b0010 || out_data4[19:10] !== exp_beat) begin failures++; $display("FAIL rr_tag c=%0d got=%b/%h exp=0010/%h", c, out_valid4, out_data4[19:10], exp_beat); end
      end
      step();
    end
    in_valid4 = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready4 = 4'b0111;
    in_valid4 = 4'b0001; in_dest4 = 8'hFF; in_data4 = 32'h3352_3130;
    @(negedge clk);
    checks++; if (in_ready4 !== 4'b0001) begin failures++; $display("FAIL bp_first got=%b exp=0001", in_ready4); end
    step();
    in_valid4 = 4'b0111; in_dest4 = 8'b11_00_11_11;
    @(negedge clk);
    checks++; if (in_ready4 !== 4'b0100) begin failures++; $display("FAIL bp_stall_ready got=%b exp=0100", in_ready4); end
    checks++; if (out_valid4 !== 4'b1000 || out_data4[39:30] !== 10'h030) begin failures++; $display("FAIL bp_hold1 got=%b/%h exp=1000/030", out_valid4, out_data4[39:30]); end
    step();
    @(negedge clk);
    checks++; if (in_ready4 !== 4'b0100 || out_valid4 !== 4'b1001) begin failures++; $display("FAIL bp_flow got=%b/%b exp=0100/1001", in_ready4, out_valid4); end
    checks++; if (out_data4[39:30] !== 10'h030 || out_data4[9:0] !== 10'h252) begin failures++; $display("FAIL bp_hold2 got=%h/%h exp=030/252", out_data4[39:30], out_data4[9:0]); end
    step();
    in_valid4 = 4'b0011; out_ready4 = 4'hF;
    @(negedge clk);
    checks++; if (in_ready4 !== 4'b0010) begin failures++; $display("FAIL bp_drain1 got=%b exp=0010", in_ready4); end
    step();
    in_valid4 = 4'b0001;
    @(negedge clk);
    checks++; if (out_valid4[3] !== 1'b1 || out_data4[39:30] !== 10'h131 || in_ready4 !== 4'b0001) begin failures++; $display("FAIL bp_drain2 got=%b/%h/%b exp=1/131/0001", out_valid4[3], out_data4[39:30], in_ready4); end
    step();
    in_valid4 = '0;
    @(negedge clk);
    checks++; if (out_valid4[3] !== 1'b1 || out_data4[39:30] !== 10'h030) begin failures++; $display("FAIL bp_drain3 got=%b/%h exp=1/030", out_valid4[3], out_data4[39:30]); end
    step();
    @(negedge clk);
    checks++; if (out_valid4 !== 4'b0000) begin failures++; $display("FAIL bp_empty got=%b exp=0000", out_valid4); end
    step();
  endtask

  task automatic test_permutation();
    do_reset();
    in_valid4 = 4'hF; in_dest4 = 8'h1B; in_data4 = 32'h1312_1110;
    @(negedge clk);
    checks++; if (in_ready4 !== 4'hF) begin failures++; $display("FAIL perm_ready got=%b exp=1111", in_ready4); end
    step();
    in_valid4 = '0;
    @(negedge clk);
    checks++; if (out_valid4 !== 4'hF) begin failures++; $display("FAIL perm_valid got=%b exp=1111", out_valid4); end
    checks++; if (out_data4 !== {10'h010, 10'h111, 10'h212, 10'h313}) begin failures++; $display("FAIL perm_data got=%h exp=%h", out_data4, {10'h010, 10'h111, 10'h212, 10'h313}); end
    step();
  endtask

  task automatic test_bad_dest();
    do_reset();
    in_valid3 = 3'b010; in_dest3 = 6'b00_11_00; in_data3 = 24'h00_7700;
    @(negedge clk);
    checks++; if (in_ready3 !== 3'b010 || err3 !== 1'b0) begin failures++; $display("FAIL bad_ready got=%b/%b exp=010/0", in_ready3, err3); end
    step();
    in_valid3 = '0;
    @(negedge clk);
    checks++; if (err3 !== 1'b1 || out_valid3 !== 3'b000) begin failures++; $display("FAIL bad_pulse got=%b/%b exp=1/000", err3, out_valid3); end
    step();
    @(negedge clk);
    checks++; if (err3 !== 1'b0) begin failures++; $display("FAIL bad_pulse_end got=%b exp=0", err3); end
    step();
  endtask

  // Reference model state for the 4-port soak.
  int         m_ptr [4];
  bit         m_ov  [4];
  logic [9:0] m_od  [4];

  task automatic test_soak_model();
    bit         p_v [4];
    int         p_d [4];
    logic [7:0] p_x [4];
    logic [3:0]  e_rdy, e_ov;
    logic [39:0] e_od;
    int g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m_ptr[i] = 0; m_ov[i] = 0; m_od[i] = '0; p_v[i] = 0; p_d[i] = 0; p_x[i] = '0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!p_v[i] && $urandom_range(0, 3) != 0) begin
          p_v[i] = 1; p_d[i] = $urandom_range(0, 3); p_x[i] = 8'($urandom);
        end
        in_valid4[i]       = p_v[i];
        in_dest4[i*2 +: 2] = 2'(p_d[i]);
        in_data4[i*8 +: 8] = p_x[i];
      end
      out_ready4 = 4'($urandom) | 4'($urandom);
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        e_ov[d] = m_ov[d];
        e_od[d*10 +: 10] = m_od[d];
      end
      checks++; if (out_valid4 !== e_ov) begin failures++; $display("FAIL soak_valid cyc=%0d got=%b exp=%b", cyc, out_valid4, e_ov); end
      checks++; if (out_data4 !== e_od) begin failures++; $display("FAIL soak_data cyc=%0d got=%h exp=%h", cyc, out_data4, e_od); end
      e_rdy = '0;
      for (int d = 0; d < 4; d++) begin
        g = -1;
        if (!m_ov[d] || out_ready4[d]) begin
          for (int k = 0; k < 4; k++) begin
            if (g < 0 && p_v[(m_ptr[d] + k) % 4] && p_d[(m_ptr[d] + k) % 4] == d) g = (m_ptr[d] + k) % 4;
          end
        end
        if (g >= 0) begin
          e_rdy[g] = 1'b1;
          m_ov[d]  = 1;
          m_od[d]  = {2'(g), p_x[g]};
          m_ptr[d] = (g + 1) % 4;
        end else if (out_ready4[d]) begin
          m_ov[d] = 0;
        end
      end
      checks++; if (in_ready4 !== e_rdy) begin failures++; $display("FAIL soak_ready cyc=%0d got=%b exp=%b", cyc, in_ready4, e_rdy); end
      for (int i = 0; i < 4; i++) if (e_rdy[i]) p_v[i] = 0;
      step();
    end
    idle_inputs();
  endtask

  // Per (src,dest) FIFO scoreboard for the 3-port soak, including bad destinations.
  logic [7:0] sb [9][$];

  task automatic test_soak_scoreboard();
    bit         p_v [3];
    int         p_d [3];
    logic [7:0] cnt [3];
    bit         exp_err, drain;
    logic [1:0] tag;
    logic [7:0] dat, want;
    int         left;
    do_reset();
    for (int k = 0; k < 9; k++) sb[k].delete();
    for (int i = 0; i < 3; i++) begin p_v[i] = 0; p_d[i] = 0; cnt[i] = '0; end
    exp_err = 0;
    for (int cyc = 0; cyc < 620; cyc++) begin
      drain = (cyc >= 600);
      for (int i = 0; i < 3; i++) begin
        if (!drain && !p_v[i] && $urandom_range(0, 2) != 0) begin
          p_v[i] = 1; p_d[i] = $urandom_range(0, 3); cnt[i] = cnt[i] + 8'd1;
        end
        in_valid3[i]       = p_v[i];
        in_dest3[i*2 +: 2] = 2'(p_d[i]);
        in_data3[i*8 +: 8] = cnt[i];
      end
      out_ready3 = drain ? 3'b111 : 3'($urandom);
      @(negedge clk);
      checks++; if (err3 !== exp_err) begin failures++; $display("FAIL sb_err cyc=%0d got=%b exp=%b", cyc, err3, exp_err); end
      exp_err = 0;
      for (int d = 0; d < 3; d++) begin
        if (out_valid3[d] && out_ready3[d]) begin
          tag = out_data3[d*10 + 8 +: 2];
          dat = out_data3[d*10 +: 8];
          checks++;
          if (tag > 2'd2 || sb[tag*3 + d].size() == 0) begin
            failures++; $display("FAIL sb_unexpected cyc=%0d out=%0d got_tag=%0d data=%h exp=queued beat", cyc, d, tag, dat);
          end else begin
            want = sb[tag*3 + d].pop_front();
            if (dat !== want) begin failures++; $display("FAIL sb_order cyc=%0d out=%0d src=%0d got=%h exp=%h", cyc, d, tag, dat, want); end
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (p_v[i] && p_d[i] == 3) begin
          exp_err = 1;
          checks++; if (in_ready3[i] !== 1'b1) begin failures++; $display("FAIL sb_bad_ready cyc=%0d in=%0d got=%b exp=1", cyc, i, in_ready3[i]); end
        end
        if (p_v[i] && in_ready3[i]) begin
          if (p_d[i] < 3) sb[i*3 + p_d[i]].push_back(cnt[i]);
          p_v[i] = 0;
        end
      end
      step();
    end
    left = 0;
    for (int k = 0; k < 9; k++) left += sb[k].size();
    checks++; if (left != 0 || out_valid3 !== 3'b000) begin failures++; $display("FAIL sb_drain got=%0d/%b exp=0/000", left, out_valid3); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single_route();
    test_contention();
    test_back_to_back();
    test_permutation();
    test_bad_dest();
    test_soak_model();
    test_soak_scoreboard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
